// File: rtl/conv_stream.sv
// conv_stream: runtime-length 1-D linear convolution engine.
// Captures L sample pairs (a[i], b[i]) from a valid/ready stream, then runs
// one MAC per cycle (j outer, i inner) into a full-precision accumulator
// bank. The 2L-1 results y[k] = sum_i a[i]*b[k-i] leave on a valid/ready
// stream, and out_last marks y[2L-2]. Each accumulator entry is cleared as
// its result is consumed, so the next frame starts from zero.
module conv_stream #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int ACC_W   = 2*DATA_W + $clog2(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_len
);

  localparam int ACC_N  = 2*MAX_LEN - 1;
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int AIDX_W = (ACC_N > 1) ? $clog2(ACC_N) : 1;
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [1:0] {IDLE, LOAD, CONV, OUT} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          len_m1;
  logic [IDX_W-1:0]          ld_idx;
  logic [IDX_W-1:0]          i_idx;
  logic [IDX_W-1:0]          j_idx;
  logic [AIDX_W-1:0]         k_idx;
  logic [AIDX_W-1:0]         last_k;

  logic signed [DATA_W-1:0]  a_mem [MAX_LEN];
  logic signed [DATA_W-1:0]  b_mem [MAX_LEN];
  logic signed [ACC_W-1:0]   acc   [ACC_N];

  logic                      in_fire;
  logic                      out_fire;
  logic [IDX_W-1:0]          cfg_m1;
  logic                      cfg_bad;
  logic [AIDX_W-1:0]         mac_idx;
  logic [AIDX_W-1:0]         k_nxt;
  logic signed [PROD_W-1:0]  prod;

  // A length of zero or above MAX_LEN is out of range for this engine.
  function automatic logic len_bad(input logic [LEN_W-1:0] l);
    return (l == '0) || (l > LEN_W'(MAX_LEN));
  endfunction

  // Effective L-1; an out-of-range request falls back to MAX_LEN.
  function automatic logic [IDX_W-1:0] len_to_m1(input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] eff;
    eff = len_bad(l) ? LEN_W'(MAX_LEN) : l;
    return IDX_W'(eff - LEN_W'(1));
  endfunction

  // Widen a full-precision product to the accumulator width; the extra
  // clog2(MAX_LEN) guard bits absorb all L-term sums, so no saturation.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cfg_m1   = len_to_m1(cfg_len);
  assign cfg_bad  = len_bad(cfg_len);
  assign mac_idx  = AIDX_W'(i_idx) + AIDX_W'(j_idx);
  assign k_nxt    = k_idx + AIDX_W'(1);
  assign prod     = PROD_W'(a_mem[i_idx]) * PROD_W'(b_mem[j_idx]);

  // Frame sequencing, loop counters and all registered handshake/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_m1    <= '0;
      ld_idx    <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      last_k    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            len_m1  <= cfg_m1;
            last_k  <= AIDX_W'(cfg_m1) << 1;
            err_len <= cfg_bad;
            ld_idx  <= IDX_W'(1);
            i_idx   <= '0;
            j_idx   <= '0;
            busy    <= 1'b1;
            if (cfg_m1 == '0) begin
              state    <= CONV;
              in_ready <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_fire) begin
            ld_idx <= ld_idx + IDX_W'(1);
            if (ld_idx == len_m1) begin
              state    <= CONV;
              in_ready <= 1'b0;
            end
          end
        end
        CONV: begin
          if (i_idx == len_m1) begin
            i_idx <= '0;
            if (j_idx == len_m1) begin
              j_idx <= '0;
              state <= OUT;
            end else begin
              j_idx <= j_idx + IDX_W'(1);
            end
          end else begin
            i_idx <= i_idx + IDX_W'(1);
          end
        end
        OUT: begin
          if (!out_valid) begin
            // First cycle in OUT: the last MAC has landed, present y[0].
            out_valid <= 1'b1;
            out_data  <= acc[0];
            out_last  <= (last_k == '0);
            k_idx     <= '0;
          end else if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              k_idx     <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              k_idx    <= k_nxt;
              out_data <= acc[k_nxt];
              out_last <= (k_nxt == last_k);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture: first beat of a frame lands at index 0, later beats at ld_idx
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < MAX_LEN; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
      end
    end else if (in_fire) begin
      if (state == IDLE) begin
        a_mem[0] <= in_a;
        b_mem[0] <= in_b;
      end else begin
        a_mem[ld_idx] <= in_a;
        b_mem[ld_idx] <= in_b;
      end
    end
  end

  // Accumulator bank: one MAC per CONV cycle; an entry clears when its result is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < ACC_N; n++) begin
        acc[n] <= '0;
      end
    end else if (state == CONV) begin
      acc[mac_idx] <= acc[mac_idx] + sext_prod(prod);
    end else if ((state == OUT) && out_fire) begin
      acc[k_idx] <= '0;
    end
  end

endmodule

// File: tb/tb_conv_stream.sv
// Self-checking bench for conv_stream: directed and randomized frames checked
// against a direct evaluation of y[k] = sum_i a[i]*b[k-i].
`timescale 1ns/1ps
module tb_conv_stream;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int ACC_W   = 2*DATA_W + $clog2(MAX_LEN);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [LEN_W-1:0]         cfg_len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;
  logic                     busy;
  logic                     err_len;

  int checks   = 0;
  int fails    = 0;
  int err_hits = 0;
  int fa [MAX_LEN];
  int fb [MAX_LEN];

  conv_stream #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  // err_len is sampled once per cycle, so a pulse of n cycles adds n.
  always @(negedge clk) begin
    if (err_len === 1'b1) err_hits++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: linear convolution of the first L entries of fa and fb.
  function automatic int ref_y(input int k, input int L);
    int s;
    s = 0;
    for (int i = 0; i < L; i++) begin
      if ((k - i >= 0) && (k - i < L)) s += fa[i] * fb[k - i];
    end
    return s;
  endfunction

  task automatic fill_random(input int L);
    for (int i = 0; i < MAX_LEN; i++) begin
      fa[i] = (i < L) ? int'($urandom_range(0, 255)) - 128 : 0;
      fb[i] = (i < L) ? int'($urandom_range(0, 255)) - 128 : 0;
    end
  endtask

  // Push n beats; cfg is presented on the first beat, noise on the rest.
  task automatic send_frame(input int cfg, input int n, input bit gaps, output bit ok);
    int idx;
    int guard;
    bit vld;
    bit rdy;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 500) begin
      vld      = !(gaps && ($urandom_range(0, 2) == 0));
      in_valid = vld;
      in_a     = DATA_W'(fa[idx]);
      in_b     = DATA_W'(fb[idx]);
      cfg_len  = (idx == 0) ? LEN_W'(cfg) : LEN_W'($urandom);
      rdy      = in_ready;
      tick;
      guard++;
      if (vld && rdy) idx++;
    end
    in_valid = 1'b0;
    checks++;
    ok = (idx == n);
    if (!ok) begin
      fails++;
      $display("FAIL input_beats: accepted %0d, required %0d", idx, n);
    end
  endtask

  // Full frame: inputs, latency, every output beat, end-of-frame state, err_len count.
  task automatic run_frame(input int cfg, input int L, input bit gaps, input int stall,
                           input bit exp_err, input string tag);
    bit ok;
    bit take;
    int base;
    int n;
    int k;
    int cyc;
    int exp_y;
    int got;
    base = err_hits;
    send_frame(cfg, L, gaps, ok);
    if (!ok) return;

    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_conv_flags: in_ready=%b busy=%b, required 0 1", tag, in_ready, busy);
    end

    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      tick;
      n++;
    end
    checks++;
    if (n !== L*L + 1) begin
      fails++;
      $display("FAIL %s_latency: %0d cycles, required %0d", tag, n, L*L + 1);
    end

    k   = 0;
    cyc = 0;
    while (k < 2*L - 1 && cyc < 400) begin
      if (stall == 0)      out_ready = 1'b1;
      else if (stall == 1) out_ready = cyc[0];
      else                 out_ready = 1'($urandom_range(0, 1));
      exp_y = ref_y(k, L);
      got   = int'(out_data);
      checks++;
      if (out_valid !== 1'b1 || got !== exp_y || out_last !== (k == 2*L - 2)) begin
        fails++;
        $display("FAIL %s_y[%0d]: valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                 tag, k, out_valid, got, out_last, exp_y, (k == 2*L - 2));
      end
      take = out_ready && (out_valid === 1'b1);
      tick;
      cyc++;
      if (take) k++;
    end
    out_ready = 1'b0;
    checks++;
    if (k !== 2*L - 1) begin
      fails++;
      $display("FAIL %s_out_count: %0d beats taken, required %0d", tag, k, 2*L - 1);
    end

    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_end_flags: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               tag, out_valid, in_ready, busy);
    end

    checks++;
    if ((err_hits - base) !== (exp_err ? 1 : 0)) begin
      fails++;
      $display("FAIL %s_err_len: %0d pulse cycles, required %0d", tag, err_hits - base, exp_err ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cfg_len   = '0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
    checks++;
    if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: %0d, required 0", out_data); end
    checks++;
    if (out_last !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: last=%b busy=%b err=%b, required 0 0 0", out_last, busy, err_len);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    fa = '{1, 2, 3, 0, 0, 0, 0, 0};
    fb = '{1, 1, 1, 0, 0, 0, 0, 0};
    run_frame(3, 3, 1'b0, 0, 1'b0, "basic");
  endtask

  task automatic test_extremes;
    for (int i = 0; i < MAX_LEN; i++) begin
      fa[i] = -128;
      fb[i] = -128;
    end
    run_frame(8, 8, 1'b0, 0, 1'b0, "extreme");
  endtask

  task automatic test_backpressure;
    fa = '{2, -3, 0, 0, 0, 0, 0, 0};
    fb = '{4, 5, 0, 0, 0, 0, 0, 0};
    run_frame(2, 2, 1'b0, 1, 1'b0, "backpressure");
  endtask

  task automatic test_bad_len;
    fill_random(8);
    run_frame(0, 8, 1'b0, 0, 1'b1, "badlen0");
    fill_random(8);
    run_frame(12, 8, 1'b1, 2, 1'b1, "badlen12");
  endtask

  task automatic test_back_to_back;
    fa = '{7, 0, 0, 0, 0, 0, 0, 0};
    fb = '{-2, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, 1, 1'b0, 0, 1'b0, "len1");
    fa = '{1, 1, 0, 0, 0, 0, 0, 0};
    fb = '{1, 1, 0, 0, 0, 0, 0, 0};
    run_frame(2, 2, 1'b0, 0, 1'b0, "after_len1");
  endtask

  task automatic test_reset_mid_conv;
    bit ok;
    fill_random(3);
    send_frame(3, 3, 1'b0, ok);
    repeat (4) tick;
    reset = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_abort: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               out_valid, in_ready, busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    fill_random(3);
    run_frame(3, 3, 1'b0, 0, 1'b0, "after_midreset");
  endtask

  task automatic test_random;
    int L;
    for (int f = 0; f < 8; f++) begin
      L = int'($urandom_range(1, MAX_LEN));
      fill_random(L);
      run_frame(L, L, 1'b1, 2, 1'b0, $sformatf("rand%0d_L%0d", f, L));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_bad_len;
    test_back_to_back;
    test_reset_mid_conv;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_stream.md
Name: conv_stream

Overview:
- Runtime-length, parametrised 1-D linear convolution engine. Successor to the fixed 8-tap convolution block.
- Accepts a frame of L sample pairs (a[i], b[i]) over a valid/ready stream and computes y[k] = sum over i of a[i]*b[k-i], for k = 0..2L-2, at full precision.
- Emits the 2L-1 results over a valid/ready stream with a last-beat marker.
- Sits between the sample capture front-end and downstream filtering/correlation logic.

Parameters:
- DATA_W, 8: signed input sample width.
- MAX_LEN, 8: maximum frame length L (>=1).
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len.
- ACC_W, 2*DATA_W+$clog2(MAX_LEN): signed result width; guarantees no overflow.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_len  in  LEN_W  frame length L; sampled on the first accepted beat of a frame only.
- in_valid  in  1  input pair valid.
- in_ready  out  1  engine can accept a pair.
- in_a  in  DATA_W  signed sample a[i].
- in_b  in  DATA_W  signed sample b[i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed y[k].
- out_last  out  1  high with y[2L-2].
- busy  out  1  high in LOAD, CONV and OUT.
- err_len  out  1  one-cycle pulse when cfg_len is 0 or >MAX_LEN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters=0.
  - Operand and result storage zeroed.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, err_len=0.
- Beat acceptance: a beat transfers only when valid && ready in the same cycle. in_ready=1 only in IDLE and LOAD.
- IDLE:
  - First accepted beat latches L=cfg_len and stores the pair at index 0.
  - If cfg_len==0 or cfg_len>MAX_LEN: L=MAX_LEN, and err_len pulses the next cycle.
  - If L==1: go to CONV. Otherwise go to LOAD.
- LOAD:
  - Store pairs at index 1..L-1.
  - After beat L-1 is accepted: go to CONV.
  - Gaps in in_valid stall LOAD indefinitely.
  - Changes on cfg_len are ignored until the next IDLE.
- CONV:
  - One MAC per cycle: acc[i+j] += a[i]*b[j].
  - Loop order: j outer, i inner. Exactly L*L cycles, then go to OUT.
  - Product is signed 2*DATA_W, sign-extended to ACC_W.
  - No saturation and no wrap, by construction.
- OUT:
  - out_valid=1, out_data=acc[k] for k=0..2L-2.
  - k advances only on an accepted beat. out_data and out_last hold stable while out_valid && !out_ready.
  - acc[k] is cleared to 0 on acceptance, so the next frame starts from zero without an extra clear phase.
  - After the beat with out_last is accepted: go to IDLE. in_ready rises in the following cycle.
- Latency: first out_valid appears L*L+1 cycles after the last input beat is accepted (no backpressure).
- Throughput: L input cycles + L*L + (2L-1) output cycles per frame.
- Reset mid-operation (any state): immediate abort. Partial frame and results are discarded; all storage is zeroed; state returns to IDLE.
- No frame overlap: a new frame is not accepted until OUT completes.

Test Plan:
- Basic: L=3, a=[1,2,3], b=[1,1,1] -> out y=[1,3,6,5,3], out_last on the 5th beat; first out_valid 10 cycles after the 3rd input beat.
- Extremes: L=8, all a=b=-128 -> y[k]=16384*(min(k,14-k)+1); peak y[7]=131072 with no overflow in 19 bits; the 15th beat carries out_last.
- Backpressure: L=2, a=[2,-3], b=[4,5]; out_ready toggles 0/1 -> y=[8,-2,-15], each value held stable while stalled.
- Bad length: cfg_len=0 on the first beat -> err_len one-cycle pulse, L=8 used, 8 beats accepted, 15 results.
- Back-to-back and L=1: frame L=1 (a=7, b=-2) -> single beat -1 4, with out_last=1; the next frame L=2 ([1,1],[1,1]) -> [1,2,1], with no residue from the prior frame.
- Reset mid-CONV: assert reset at cycle 5 of CONV -> out_valid=0 and in_ready=1 right after release; the following frame L=3 gives the correct results.
